// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state codes,
// ALU/PC select codes and the control-word payload.
package multicycle_control_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_ERROR    = 4'd12
  } state_e;

  typedef struct packed {
    logic             pcwrite;
    logic             pcwritecond;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [SEL_W-1:0] alusrcb;
    logic [SEL_W-1:0] aluop;
    logic [SEL_W-1:0] pcsrc;
  } ctrl_t;

  // States that perform a memory access and stall until it completes.
  function automatic logic waits_on_mem(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (lw/sw/R-type/beq/addi/j)
// with an optional memory ready handshake and a sticky illegal-opcode flag.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [SEL_W-1:0] alusrcb,
  output logic [SEL_W-1:0] aluop,
  output logic [SEL_W-1:0] pcsrc,
  output logic             pc_en,
  output logic             illegal,
  output logic [ST_W-1:0]  state
);

  state_e r_state;
  state_e w_next;
  logic   r_illegal;
  logic   w_mem_ready;
  ctrl_t  w_ctrl;

  assign w_mem_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State register and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ERROR) r_illegal <= 1'b1;
    end
  end

  // Next-state logic; memory states hold until the access completes.
  always_comb begin
    w_next = r_state;
    if (!(waits_on_mem(r_state) && !w_mem_ready)) begin
      case (r_state)
        S_FETCH:  w_next = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_RTYPE_EX;
            OP_BEQ:       w_next = S_BEQ;
            OP_ADDI:      w_next = S_ADDI_EX;
            OP_J:         w_next = S_JUMP;
            default:      w_next = S_ERROR;
          endcase
        end
        S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    w_next = S_MEMWB;
        S_RTYPE_EX: w_next = S_RTYPE_WB;
        S_ADDI_EX:  w_next = S_ADDI_WB;
        S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BEQ, S_ADDI_WB, S_JUMP:
                    w_next = S_FETCH;
        S_ERROR:    w_next = S_ERROR;
        default:    w_next = S_ERROR;
      endcase
    end
  end

  // Output decode from the state register; write enables are held low in reset.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.memread = 1'b1;
        w_ctrl.irwrite = w_mem_ready;
        w_ctrl.pcwrite = w_mem_ready;
        w_ctrl.alusrcb = SRCB_FOUR;
        w_ctrl.aluop   = ALUOP_ADD;
        w_ctrl.pcsrc   = PCSRC_ALU;
      end
      S_DECODE: begin
        w_ctrl.alusrcb = SRCB_IMM_SH;
        w_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_ctrl.iord    = 1'b1;
        w_ctrl.memread = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      S_RTYPE_EX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_B;
        w_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        w_ctrl.regwrite = 1'b1;
        w_ctrl.regdst   = 1'b1;
      end
      S_BEQ: begin
        w_ctrl.alusrca     = 1'b1;
        w_ctrl.alusrcb     = SRCB_B;
        w_ctrl.aluop       = ALUOP_SUB;
        w_ctrl.pcsrc       = PCSRC_ALUOUT;
        w_ctrl.pcwritecond = 1'b1;
      end
      S_ADDI_WB: w_ctrl.regwrite = 1'b1;
      S_JUMP: begin
        w_ctrl.pcsrc   = PCSRC_JUMP;
        w_ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      w_ctrl.pcwrite     = 1'b0;
      w_ctrl.pcwritecond = 1'b0;
      w_ctrl.irwrite     = 1'b0;
      w_ctrl.memwrite    = 1'b0;
      w_ctrl.regwrite    = 1'b0;
      w_ctrl.memread     = 1'b0;
    end
  end

  assign pcwrite     = w_ctrl.pcwrite;
  assign pcwritecond = w_ctrl.pcwritecond;
  assign iord        = w_ctrl.iord;
  assign memread     = w_ctrl.memread;
  assign memwrite    = w_ctrl.memwrite;
  assign irwrite     = w_ctrl.irwrite;
  assign memtoreg    = w_ctrl.memtoreg;
  assign regdst      = w_ctrl.regdst;
  assign regwrite    = w_ctrl.regwrite;
  assign alusrca     = w_ctrl.alusrca;
  assign alusrcb     = w_ctrl.alusrcb;
  assign aluop       = w_ctrl.aluop;
  assign pcsrc       = w_ctrl.pcsrc;
  assign pc_en       = w_ctrl.pcwrite | (w_ctrl.pcwritecond & zero);
  assign illegal     = r_illegal;
  assign state       = ST_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a random
// instruction stream checked against a per-instruction step-list model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, nh_opcode;
  logic       zero, mem_ready, nh_zero, nh_mem_ready;

  logic d_pcwrite, d_pcwritecond, d_iord, d_memread, d_memwrite, d_irwrite;
  logic d_memtoreg, d_regdst, d_regwrite, d_alusrca, d_pc_en, d_illegal;
  logic [1:0] d_alusrcb, d_aluop, d_pcsrc;
  logic [3:0] d_state;

  logic n_pcwrite, n_pcwritecond, n_iord, n_memread, n_memwrite, n_irwrite;
  logic n_memtoreg, n_regdst, n_regwrite, n_alusrca, n_pc_en, n_illegal;
  logic [1:0] n_alusrcb, n_aluop, n_pcsrc;
  logic [3:0] n_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_HANDSHAKE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(d_pcwrite), .pcwritecond(d_pcwritecond), .iord(d_iord), .memread(d_memread),
    .memwrite(d_memwrite), .irwrite(d_irwrite), .memtoreg(d_memtoreg), .regdst(d_regdst),
    .regwrite(d_regwrite), .alusrca(d_alusrca), .alusrcb(d_alusrcb), .aluop(d_aluop),
    .pcsrc(d_pcsrc), .pc_en(d_pc_en), .illegal(d_illegal), .state(d_state)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b0)) u_dut_nh (
    .clk(clk), .rst_n(rst_n), .opcode(nh_opcode), .zero(nh_zero), .mem_ready(nh_mem_ready),
    .pcwrite(n_pcwrite), .pcwritecond(n_pcwritecond), .iord(n_iord), .memread(n_memread),
    .memwrite(n_memwrite), .irwrite(n_irwrite), .memtoreg(n_memtoreg), .regdst(n_regdst),
    .regwrite(n_regwrite), .alusrca(n_alusrca), .alusrcb(n_alusrcb), .aluop(n_aluop),
    .pcsrc(n_pcsrc), .pc_en(n_pc_en), .illegal(n_illegal), .state(n_state)
  );

  logic [21:0] obs, nh_obs;
  logic [6:0]  d_writes;
  assign obs = {d_pcwrite, d_pcwritecond, d_iord, d_memread, d_memwrite, d_irwrite,
                d_memtoreg, d_regdst, d_regwrite, d_alusrca, d_alusrcb, d_aluop,
                d_pcsrc, d_pc_en, d_illegal, d_state};
  assign nh_obs = {n_pcwrite, n_pcwritecond, n_iord, n_memread, n_memwrite, n_irwrite,
                   n_memtoreg, n_regdst, n_regwrite, n_alusrca, n_alusrcb, n_aluop,
                   n_pcsrc, n_pc_en, n_illegal, n_state};
  assign d_writes = {d_pcwrite, d_pcwritecond, d_pc_en, d_irwrite, d_memwrite,
                     d_regwrite, d_memread};

  // Expected control word for one step of an instruction, straight from the state table.
  function automatic logic [21:0] model_out(state_e s, logic mr, logic z);
    logic pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
    logic [1:0] sb, op, ps;
    {pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, ill} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      S_FETCH:    begin mrd = 1'b1; irw = mr; pw = mr; sb = 2'b01; end
      S_DECODE:   sb = 2'b11;
      S_MEMADR:   begin sa = 1'b1; sb = 2'b10; end
      S_MEMRD:    begin io = 1'b1; mrd = 1'b1; end
      S_MEMWB:    begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:    begin io = 1'b1; mwr = 1'b1; end
      S_RTYPE_EX: begin sa = 1'b1; op = 2'b10; end
      S_RTYPE_WB: begin rw = 1'b1; rdst = 1'b1; end
      S_BEQ:      begin sa = 1'b1; op = 2'b01; ps = 2'b01; pwc = 1'b1; end
      S_ADDI_EX:  begin sa = 1'b1; sb = 2'b10; end
      S_ADDI_WB:  rw = 1'b1;
      S_JUMP:     begin ps = 2'b10; pw = 1'b1; end
      default:    ill = 1'b1;
    endcase
    return {pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, sb, op, ps,
            pw | (pwc & z), ill, 4'(s)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP_LW; mem_ready = 1'b1; zero = 1'b1;
    nh_opcode = OP_RTYPE; nh_mem_ready = 1'b0; nh_zero = 1'b0;
    #3;
    n_tests++;
    if (d_state !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", d_state, 4'(S_FETCH));
    end
    n_tests++;
    if (d_writes !== 7'b0) begin
      n_fail++; $display("FAIL reset_writes: got %b expected 0000000", d_writes);
    end
    n_tests++;
    if (d_illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_illegal: got %b expected 0", d_illegal);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_tests++;
    if (d_state !== 4'(S_DECODE)) begin
      n_fail++; $display("FAIL first_fetch: got %0d expected %0d", d_state, 4'(S_DECODE));
    end
  endtask

  task automatic test_lw();
    state_e exp_s[6];
    exp_s = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
    do_reset();
    opcode = OP_LW; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tests++;
      if (d_state !== 4'(exp_s[i])) begin
        n_fail++; $display("FAIL lw_state: step %0d got %0d expected %0d", i, d_state, 4'(exp_s[i]));
      end
      n_tests++;
      if ({d_regwrite, d_memtoreg} !== ((i == 4) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("FAIL lw_wb: step %0d got %b expected %b", i,
                           {d_regwrite, d_memtoreg}, (i == 4) ? 2'b11 : 2'b00);
      end
      step();
    end
  endtask

  task automatic test_sw_wait();
    do_reset();
    opcode = OP_SW; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      n_tests++;
      if ({d_state, d_memwrite, d_regwrite} !== {4'(S_MEMWR), 2'b10}) begin
        n_fail++; $display("FAIL sw_wait: cycle %0d got state %0d mw %b rw %b expected state %0d mw 1 rw 0",
                           i, d_state, d_memwrite, d_regwrite, 4'(S_MEMWR));
      end
      step();
    end
    n_tests++;
    if (d_state !== 4'(S_FETCH)) begin
      n_fail++; $display("FAIL sw_return: got %0d expected %0d", d_state, 4'(S_FETCH));
    end
  endtask

  task automatic test_beq();
    logic zz;
    for (int t = 0; t < 2; t++) begin
      zz = (t == 0);
      do_reset();
      opcode = OP_BEQ; mem_ready = 1'b1; zero = ~zz;
      repeat (2) step();
      zero = zz;
      #1;
      n_tests++;
      if ({d_state, d_pc_en} !== {4'(S_BEQ), zz}) begin
        n_fail++; $display("FAIL beq_pc_en: zero %b got state %0d pc_en %b expected state %0d pc_en %b",
                           zz, d_state, d_pc_en, 4'(S_BEQ), zz);
      end
      step();
      n_tests++;
      if (d_state !== 4'(S_FETCH)) begin
        n_fail++; $display("FAIL beq_return: got %0d expected %0d", d_state, 4'(S_FETCH));
      end
    end
  endtask

  task automatic test_random(input int n_instr);
    state_e      seq[$];
    logic [21:0] exp_v;
    int          idx;
    do_reset();
    for (int k = 0; k < n_instr; k++) begin
      case ($urandom_range(0, 5))
        0: opcode = OP_LW;
        1: opcode = OP_SW;
        2: opcode = OP_RTYPE;
        3: opcode = OP_BEQ;
        4: opcode = OP_ADDI;
        default: opcode = OP_J;
      endcase
      seq.delete();
      seq.push_back(S_FETCH);
      seq.push_back(S_DECODE);
      case (opcode)
        OP_LW:    begin seq.push_back(S_MEMADR); seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
        OP_SW:    begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWR); end
        OP_RTYPE: begin seq.push_back(S_RTYPE_EX); seq.push_back(S_RTYPE_WB); end
        OP_BEQ:   seq.push_back(S_BEQ);
        OP_ADDI:  begin seq.push_back(S_ADDI_EX); seq.push_back(S_ADDI_WB); end
        default:  seq.push_back(S_JUMP);
      endcase
      idx = 0;
      while (idx < seq.size()) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        zero = 1'($urandom_range(0, 1));
        #1;
        exp_v = model_out(seq[idx], mem_ready, zero);
        n_tests++;
        if (obs !== exp_v) begin
          n_fail++; $display("FAIL random_ctrl: instr %0d op %b step %0d got %h expected %h",
                             k, opcode, idx, obs, exp_v);
        end
        n_tests++;
        if ((d_memwrite & d_regwrite) !== 1'b0) begin
          n_fail++; $display("FAIL mw_rw_excl: instr %0d got mw %b rw %b expected not both",
                             k, d_memwrite, d_regwrite);
        end
        if (!(!mem_ready && (seq[idx] == S_FETCH || seq[idx] == S_MEMRD || seq[idx] == S_MEMWR)))
          idx++;
        step();
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'b111111; mem_ready = 1'b1; zero = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if ({d_state, d_illegal, d_writes} !== {4'(S_ERROR), 1'b1, 7'b0}) begin
        n_fail++; $display("FAIL error_hold: cycle %0d got state %0d ill %b writes %b expected state %0d ill 1 writes 0",
                           i, d_state, d_illegal, d_writes, 4'(S_ERROR));
      end
      step();
    end
    #1; rst_n = 1'b0; #1;
    n_tests++;
    if ({d_state, d_illegal} !== {4'(S_FETCH), 1'b0}) begin
      n_fail++; $display("FAIL error_reset: got state %0d ill %b expected state %0d ill 0",
                         d_state, d_illegal, 4'(S_FETCH));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = OP_LW; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) step();
    mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({d_state, d_memread} !== {4'(S_MEMRD), 1'b1}) begin
      n_fail++; $display("FAIL memrd_entry: got state %0d mr %b expected state %0d mr 1",
                         d_state, d_memread, 4'(S_MEMRD));
    end
    #1; rst_n = 1'b0; #1;
    n_tests++;
    if ({d_state, d_memread, d_illegal, d_writes} !== {4'(S_FETCH), 2'b00, 7'b0}) begin
      n_fail++; $display("FAIL mid_reset: got state %0d mr %b ill %b writes %b expected state %0d mr 0 ill 0 writes 0",
                         d_state, d_memread, d_illegal, d_writes, 4'(S_FETCH));
    end
  endtask

  task automatic test_no_handshake();
    state_e      exp_s[5];
    logic [21:0] exp_v;
    exp_s = '{S_FETCH, S_DECODE, S_RTYPE_EX, S_RTYPE_WB, S_FETCH};
    nh_opcode = OP_RTYPE; nh_mem_ready = 1'b0; nh_zero = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_v = model_out(exp_s[i], 1'b1, nh_zero);
      n_tests++;
      if (nh_obs !== exp_v) begin
        n_fail++; $display("FAIL nohs_rtype: step %0d got %h expected %h", i, nh_obs, exp_v);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_random(40);
    test_illegal();
    test_reset_mid();
    test_no_handshake();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
